// File: rtl/irq_ctrl_if.sv
// Bus-slave access port of the interrupt controller: active-low strobes,
// registered read data and an active-low access-complete.
interface irq_ctrl_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt request controller: latches level/edge device interrupts into PEND and
// forwards PEND & IRQ_EN to the CPU. Define IRQ_CTRL_SYNC_EN for a 2-flop input synchronizer.
module irq_ctrl #(
  parameter int CPU_IRQ_CH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CPU_IRQ_CH-1:0] src_irq,
  irq_ctrl_if.slave             bus,
  output logic [CPU_IRQ_CH-1:0] irq
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic [CPU_IRQ_CH-1:0] s;
  logic [CPU_IRQ_CH-1:0] s_d;
  logic [CPU_IRQ_CH-1:0] pend;
  logic [CPU_IRQ_CH-1:0] irq_en;
  logic [CPU_IRQ_CH-1:0] mode;

  logic                  acc;
  logic                  wr_acc;
  logic [CPU_IRQ_CH-1:0] clr;
  logic [CPU_IRQ_CH-1:0] set;
  logic [CPU_IRQ_CH-1:0] rise;
  logic [CPU_IRQ_CH-1:0] pend_next;
  logic [CPU_IRQ_CH-1:0] en_next;
  logic [CPU_IRQ_CH-1:0] mode_next;
  logic [31:0]           rd_val;
  logic                  unused_wr_data;

  assign unused_wr_data = ^bus.wr_data;

  // Stage p0: input capture of the asynchronous device lines
`ifdef IRQ_CTRL_SYNC_EN
  logic [CPU_IRQ_CH-1:0] sync_p0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= '0;
      s       <= '0;
    end else begin
      sync_p0 <= src_irq;
      s       <= sync_p0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) s <= '0;
    else        s <= src_irq;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) s_d <= '0;
    else        s_d <= s;
  end

  // Stage p1: event detection, register update and bus decode
  assign acc    = !bus.cs_ && !bus.as_;
  assign wr_acc = acc && !bus.rw;
  assign rise   = s & ~s_d;
  assign set    = (mode & rise) | (~mode & s);

  always_comb begin
    clr       = '0;
    en_next   = irq_en;
    mode_next = mode;
    if (wr_acc) begin
      case (bus.addr)
        A_PEND:  clr       = bus.wr_data[CPU_IRQ_CH-1:0];
        A_EN:    en_next   = bus.wr_data[CPU_IRQ_CH-1:0];
        A_MODE:  mode_next = bus.wr_data[CPU_IRQ_CH-1:0];
        default: ;
      endcase
    end
  end

  // Set is OR-ed in after the clear so a same-cycle event is never lost.
  assign pend_next = (pend & ~clr) | set;

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      A_PEND:  rd_val[CPU_IRQ_CH-1:0] = pend;
      A_EN:    rd_val[CPU_IRQ_CH-1:0] = irq_en;
      A_MODE:  rd_val[CPU_IRQ_CH-1:0] = mode;
      A_RAW:   rd_val[CPU_IRQ_CH-1:0] = s;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend   <= '0;
      irq_en <= '0;
      mode   <= '0;
    end else begin
      pend   <= pend_next;
      irq_en <= en_next;
      mode   <= mode_next;
    end
  end

  // Stage p2: registered outputs to CPU and bus
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq         <= '0;
      bus.rd_data <= '0;
      bus.rdy_    <= 1'b1;
    end else begin
      irq         <= pend_next & en_next;
      bus.rd_data <= (acc && bus.rw) ? rd_val : 32'd0;
      bus.rdy_    <= !acc;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; latency constants follow IRQ_CTRL_SYNC_EN.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_irq;
  logic [7:0] irq;
  logic [31:0] rdv;
  int         n_checks = 0;
  int         n_fail   = 0;

  irq_ctrl_if bus();

  irq_ctrl #(.CPU_IRQ_CH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b0; bus.addr = a; bus.wr_data = d;
    tick();
    bus.cs_ = 1'b1; bus.as_ = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b1; bus.addr = a; bus.wr_data = '0;
    tick();
    check_eq("rdy_low_on_read", {31'd0, bus.rdy_}, 32'd0);
    d = bus.rd_data;
    bus.cs_ = 1'b1; bus.as_ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; src_irq = 8'hFF;
    bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = 2'd0; bus.wr_data = '0;

    // reset state
    repeat (3) tick();
    check_eq("irq_in_reset", {24'd0, irq}, 32'd0);
    check_eq("rdy_in_reset", {31'd0, bus.rdy_}, 32'd1);
    src_irq = 8'h00; reset = 1'b1;
    bus_rd(2'd0, rdv); check_eq("pend_after_reset", rdv, 32'd0);
    bus_rd(2'd1, rdv); check_eq("en_after_reset", rdv, 32'd0);
    bus_rd(2'd2, rdv); check_eq("mode_after_reset", rdv, 32'd0);
    tick();
    check_eq("rdy_idle", {31'd0, bus.rdy_}, 32'd1);
    check_eq("rd_data_idle", bus.rd_data, 32'd0);

    // level mode
    bus_wr(2'd1, 32'h01);
    src_irq = 8'h01;
    repeat (LAT - 1) tick();
    check_eq("level_irq_early", {24'd0, irq}, 32'd0);
    tick();
    check_eq("level_irq_set", {24'd0, irq}, 32'h01);
    bus_wr(2'd0, 32'h01);
    check_eq("level_clr_src_high", {24'd0, irq}, 32'h01);
    src_irq = 8'h00;
    repeat (LAT) tick();
    check_eq("level_held", {24'd0, irq}, 32'h01);
    bus_wr(2'd0, 32'h01);
    check_eq("level_clr_src_low", {24'd0, irq}, 32'd0);
    bus_rd(2'd0, rdv); check_eq("level_pend_clear", rdv, 32'd0);

    // edge mode
    bus_wr(2'd2, 32'h80);
    bus_wr(2'd1, 32'h80);
    src_irq = 8'h80;
    tick();
    src_irq = 8'h00;
    repeat (LAT + 1) tick();
    check_eq("edge_irq", {24'd0, irq}, 32'h80);
    bus_rd(2'd0, rdv); check_eq("edge_pend_held", rdv, 32'h80);
    bus_wr(2'd0, 32'h80);
    check_eq("edge_irq_clr", {24'd0, irq}, 32'd0);
    bus_rd(2'd0, rdv); check_eq("edge_pend_clr", rdv, 32'd0);

    // simultaneous set and clear on channel 3
    bus_wr(2'd2, 32'h88);
    src_irq = 8'h08;
    tick();
    repeat (LAT - 2) tick();
    bus_wr(2'd0, 32'h08);
    bus_rd(2'd0, rdv); check_eq("set_beats_clr", rdv, 32'h08);
    src_irq = 8'h00;
    repeat (LAT) tick();
    bus_wr(2'd0, 32'h08);
    bus_rd(2'd0, rdv); check_eq("ch3_cleared", rdv, 32'd0);

    // masked pending on channel 2
    bus_wr(2'd1, 32'h00);
    bus_wr(2'd2, 32'h04);
    src_irq = 8'h04;
    tick();
    src_irq = 8'h00;
    repeat (LAT + 1) tick();
    check_eq("masked_irq", {24'd0, irq}, 32'd0);
    bus_rd(2'd0, rdv); check_eq("masked_pend", rdv, 32'h04);
    bus_wr(2'd1, 32'h04);
    check_eq("unmask_irq", {24'd0, irq}, 32'h04);
    bus_rd(2'd2, rdv); check_eq("mode_readback", rdv, 32'h04);

    // RAW read, then reset on a write strobe
    src_irq = 8'hA5;
    repeat (LAT) tick();
    bus_rd(2'd3, rdv); check_eq("raw_read", rdv, 32'h000000A5);
    tick();
    check_eq("rdy_one_cycle", {31'd0, bus.rdy_}, 32'd1);
    check_eq("rd_data_cleared", bus.rd_data, 32'd0);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b0; bus.addr = 2'd1; bus.wr_data = 32'hFF;
    reset = 1'b0;
    tick();
    bus.cs_ = 1'b1; bus.as_ = 1'b1;
    reset = 1'b1;
    check_eq("rdy_aborted", {31'd0, bus.rdy_}, 32'd1);
    check_eq("irq_aborted", {24'd0, irq}, 32'd0);
    tick();
    check_eq("rdy_stays_high", {31'd0, bus.rdy_}, 32'd1);
    bus_rd(2'd1, rdv); check_eq("en_not_written", rdv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt request controller sitting between peripheral interrupt sources and the CPU's 8-channel `irq` input. Synchronizes and latches up to 8 device interrupt lines, each either level- or rising-edge-triggered. Drives a registered, per-channel-enabled pending vector to the CPU. Exposes pending/enable/mode/raw registers to software through a bus-slave port.

## Interface
- `CPU_IRQ_CH`, default 8: number of interrupt channels; sets the width of `src_irq` and `irq`.
- `clk`  in  1: system clock.
- `reset`  in  1: reset, synchronous and active-low, sampled on rising `clk`.
- `src_irq`  in  CPU_IRQ_CH: raw device interrupt lines, active-high, asynchronous to `clk`.
- `cs_`  in  1: chip select, active-low.
- `as_`  in  1: address strobe, active-low, one-cycle pulse per access.
- `rw`  in  1: 1 = read, 0 = write.
- `addr`  in  2: register word index.
- `wr_data`  in  32: write data; only bits [CPU_IRQ_CH-1:0] are used.
- `rd_data`  out  32: read data, valid while `rdy_` is low, 0 otherwise.
- `rdy_`  out  1: access-complete, active-low.
- `irq`  out  CPU_IRQ_CH: registered `pend & irq_en`, connected to the CPU `irq` input.

## Operation
- Register map (by `addr`):
  - 0 PEND: read returns pending bits; write-1-to-clear.
  - 1 IRQ_EN: R/W; 1 = channel forwarded to `irq`.
  - 2 MODE: R/W; 1 = rising-edge, 0 = level.
  - 3 RAW: read returns synchronized source level `s`; writes ignored.
  - Read bits above CPU_IRQ_CH are 0.
- Source path: `src_irq` → input stage → `s`; `s_d` = `s` delayed one cycle.
  - `rise = s & ~s_d`.
  - `set = MODE ? rise : s`.
- Pending update every cycle: `pend_next = (pend & ~clr) | set`.
  - `clr` is `wr_data` bits on a PEND write access, else 0.
- `irq` register loads `pend_next & en_next` each cycle.
  - `en_next` is IRQ_EN including any write in the same cycle.
- Access accepted on a rising edge where `cs_`=0 and `as_`=0.
  - Writes update the addressed register at that edge.
  - Read data is the register value before that edge's update.
  - Data is captured into `rd_data` at that edge, together with `rdy_`=0.
- Boundary conditions:
  - Set and clear on the same bit in the same cycle: set wins.
  - A level-mode bit with its source still high re-pends immediately after a clear.
  - A MODE or IRQ_EN change never alters PEND.
  - A disabled channel still pends; enabling it later raises `irq` with no new event.
  - `s_d` resets to 0, so an edge-mode source already high when reset is released registers one rise.
  - Reset asserted mid-access aborts the access: `rdy_` goes high and no register is written.

## Timing
- Reset values:
  - `irq`=0, `rd_data`=0, `rdy_`=1.
  - PEND=0, IRQ_EN=0, MODE=0 (level).
  - `s`, `s_d` and all synchronizer flops = 0.
- Source to `irq`, without IRQ_CTRL_SYNC_EN:
  - `src_irq` high before edge N.
  - `s`=1 after edge N.
  - `pend`/`irq`=1 after edge N+1.
- With IRQ_CTRL_SYNC_EN: one cycle more, so `irq`=1 after edge N+2.
- Bus: strobe sampled at edge N.
  - `rdy_`=0 and `rd_data` valid for exactly the cycle after edge N.
  - Both return to 1/0 after edge N+1.
  - A new strobe is accepted at earliest at edge N+1; `rdy_` then stays low a second cycle.
- IRQ_EN write at edge N changes `irq` after edge N.
- PEND clear at edge N drops `irq` after edge N (unless set wins).

## Configuration
- `IRQ_CTRL_SYNC_EN` defined:
  - Input stage is a 2-flop synchronizer per channel.
  - Use when sources come from another clock domain.
- Undefined:
  - Input stage is a single register.
  - All latencies drop by one cycle.
  - Register map and bus timing are unchanged.

## Test plan
- Reset state: hold `reset`=0 for 3 cycles with `src_irq`=8'hFF, then release. Required:
  - `irq`=0 and `rdy_`=1 during reset.
  - Reads return 0 for PEND, IRQ_EN and MODE.
- Level mode: write IRQ_EN=8'h01, raise `src_irq[0]`. Required:
  - `irq`=8'h01 after the macro-dependent latency.
  - Writing PEND=8'h01 while the source is high leaves `irq`=8'h01.
  - Dropping the source, then writing PEND=8'h01, gives `irq`=0 the next cycle.
- Edge mode: write MODE=8'h80, IRQ_EN=8'h80, then give `src_irq[7]` a 1-cycle pulse. Required:
  - PEND reads 8'h80 and stays set after the pulse ends.
  - A PEND write of 8'h80 clears it.
- Simultaneous set/clear: in edge mode, arrange a rise on channel 3 at the same edge as a PEND write of 8'h08. Required: PEND reads 8'h08 afterwards.
- Masked pending: with IRQ_EN=0, pulse `src_irq[2]` in edge mode. Required:
  - `irq`=0 and PEND=8'h04.
  - After writing IRQ_EN=8'h04, `irq`=8'h04 the next cycle.
- Bus/reset: issue a read of RAW with `src_irq`=8'hA5 stable, then assert `reset` on the strobe edge of a following IRQ_EN write of 8'hFF. Required:
  - The RAW read returns 32'h000000A5 with `rdy_`=0 for one cycle.
  - After the reset, IRQ_EN reads 0 and `rdy_` stays 1.
